// File: rtl/perip_bus_pkg.sv
// Shared definitions for the peripheral bus initiator: FSM states, slave map and
// the address field that selects the target slave.
package perip_bus_pkg;

    localparam int SEL_LSB = 28;
    localparam int SEL_W   = 4;

    localparam int SLV_TIMER = 0;
    localparam int SLV_UART  = 1;
    localparam int SLV_GPIO  = 2;
    localparam int SLV_SPI   = 3;

    typedef enum logic [3:0] {
        IDLE,
        ERR,
        WR,
        RD_A,
        RD_D,
        RMW_A,
        RMW_D,
        RMW_W,
        RSP
    } state_e;

endpackage

// File: rtl/perip_addr_decode.sv
// Combinational slave select: the top address nibble is the slave index, and it is
// valid only when it names an existing slave.
module perip_addr_decode
    import perip_bus_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [SEL_W-1:0]  idx_o,
    output logic              valid_o
);

    logic unused_addr;

    assign idx_o       = addr_i[SEL_LSB +: SEL_W];
    assign valid_o     = (32'(idx_o) < NUM_SLV);
    assign unused_addr = ^addr_i[SEL_LSB-1:0];

endmodule

// File: rtl/perip_bus_master.sv
// Peripheral register bus initiator: one core load/store at a time, slave decode,
// read-modify-write for partial stores, one response pulse per accepted request.
module perip_bus_master
    import perip_bus_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic [DATA_W-1:0]         req_wdata_i,
    input  logic [DATA_W/8-1:0]       req_be_i,
    output logic                      rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [NUM_SLV-1:0]        slv_wen_o,
    output logic [ADDR_W-1:0]         slv_waddr_o,
    output logic [DATA_W-1:0]         slv_wdata_o,
    output logic [ADDR_W-1:0]         slv_raddr_o,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata_i
);

    localparam int BE_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [BE_W-1:0]   be_q, be_d;

    logic [NUM_SLV-1:0] wen_q, wen_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [SEL_W-1:0]  dec_idx;
    logic              dec_valid;
    logic              accept;
    logic [ADDR_W-1:0] req_addr_al;
    logic [DATA_W-1:0] rdata_sel;
    logic [DATA_W-1:0] merged;

    perip_addr_decode #(
        .NUM_SLV (NUM_SLV),
        .ADDR_W  (ADDR_W)
    ) u_decode (
        .addr_i  (req_addr_i),
        .idx_o   (dec_idx),
        .valid_o (dec_valid)
    );

    function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_SLV-1:0] oh;
        oh = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            oh[k] = (32'(idx) == k);
        end
        return oh;
    endfunction

    // The RSP cycle also accepts, so a waiting core loses no cycle between requests.
    assign req_ready_o = (state_q == IDLE) || (state_q == RSP);
    assign accept      = req_valid_i && req_ready_o;
    assign req_addr_al = {req_addr_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (32'(idx_q) == k) begin
                rdata_sel = slv_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        merged = rdata_sel;
        for (int b = 0; b < BE_W; b++) begin
            if (be_q[b]) begin
                merged[b*8 +: 8] = req_wdata_q[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        req_wdata_d = req_wdata_q;
        be_d        = be_q;
        wen_d       = '0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        case (state_q)
            IDLE, RSP: begin
                state_d = IDLE;
                if (accept) begin
                    idx_d       = dec_idx;
                    addr_d      = req_addr_al;
                    req_wdata_d = req_wdata_i;
                    be_d        = req_be_i;
                    if (!dec_valid) begin
                        state_d = ERR;
                    end else if (!req_we_i) begin
                        state_d = RD_A;
                        raddr_d = req_addr_al;
                    end else if (&req_be_i) begin
                        state_d = WR;
                        wen_d   = onehot(dec_idx);
                        waddr_d = req_addr_al;
                        wdata_d = req_wdata_i;
                    end else if (req_be_i == '0) begin
                        // Empty store: walk the WR timing with no strobe.
                        state_d = WR;
                    end else begin
                        state_d = RMW_A;
                        raddr_d = req_addr_al;
                    end
                end
            end
            ERR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
            end
            RD_A: begin
                state_d = RD_D;
            end
            RD_D: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = rdata_sel;
            end
            RMW_A: begin
                state_d = RMW_D;
            end
            RMW_D: begin
                state_d = RMW_W;
                wen_d   = onehot(idx_q);
                waddr_d = addr_q;
                wdata_d = merged;
            end
            RMW_W: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            req_wdata_q <= '0;
            be_q        <= '0;
            wen_q       <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            req_wdata_q <= req_wdata_d;
            be_q        <= be_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign slv_wen_o   = wen_q;
    assign slv_waddr_o = waddr_q;
    assign slv_wdata_o = wdata_q;
    assign slv_raddr_o = raddr_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_perip_bus_master.sv
// Directed bench for perip_bus_master with a small registered-read slave memory model
// and an expected-response queue.
module tb_perip_bus_master;

    localparam int NUM_SLV = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_we_i;
    logic [ADDR_W-1:0]         req_addr_i;
    logic [DATA_W-1:0]         req_wdata_i;
    logic [DATA_W/8-1:0]       req_be_i;
    logic                      rsp_valid_o;
    logic [DATA_W-1:0]         rsp_rdata_o;
    logic                      rsp_err_o;
    logic [NUM_SLV-1:0]        slv_wen_o;
    logic [ADDR_W-1:0]         slv_waddr_o;
    logic [DATA_W-1:0]         slv_wdata_o;
    logic [ADDR_W-1:0]         slv_raddr_o;
    logic [NUM_SLV*DATA_W-1:0] slv_rdata_i = '0;

    int total = 0;
    int bad   = 0;
    int wen_cnt = 0;
    int rsp_cnt = 0;
    int n_exp   = 0;
    int wen_mark;
    int rsp_mark;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] mem [NUM_SLV][16];

    perip_bus_master #(
        .NUM_SLV (NUM_SLV),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .slv_wen_o   (slv_wen_o),
        .slv_waddr_o (slv_waddr_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_raddr_o (slv_raddr_o),
        .slv_rdata_i (slv_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Slaves: 16 words each, write on wen, registered read with one cycle latency.
    always @(posedge clk_i) begin
        for (int k = 0; k < NUM_SLV; k++) begin
            if (slv_wen_o[k]) begin
                mem[k][slv_waddr_o[5:2]] <= slv_wdata_o;
            end
            slv_rdata_i[k*DATA_W +: DATA_W] <= mem[k][slv_raddr_o[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rsp_valid_o === 1'b1) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL rsp_unexpected: observed rdata=%h err=%b expected no response",
                       rsp_rdata_o, rsp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, mon_e[31:0]);
                check("rsp_err", 32'(rsp_err_o), 32'(mon_e[32]));
            end
        end
        if (|slv_wen_o) begin
            wen_cnt++;
            check("wen_onehot", 32'($countones(slv_wen_o)), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_rsp(input logic err, input logic [31:0] data);
        exp_q.push_back({err, data});
        n_exp++;
    endtask

    // Presents one request and returns in cycle T+1 with valid dropped.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        req_valid_i = 1'b1;
        check("ready_at_issue", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic store_full(input logic [31:0] addr, input logic [31:0] data);
        expect_rsp(1'b0, 32'h0);
        issue(1'b1, addr, data, 4'hF);
        tick();
        tick();
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        tick();
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_wen", 32'(slv_wen_o), 32'd0);
        check("rst_raddr", slv_raddr_o, 32'h0);
        check("rst_waddr", slv_waddr_o, 32'h0);
        check("rst_wdata", slv_wdata_o, 32'h0);
        check("rst_rdata", rsp_rdata_o, 32'h0);
        check("rst_err", 32'(rsp_err_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // Full store to slave 0.
        expect_rsp(1'b0, 32'h0);
        issue(1'b1, 32'h0000_0008, 32'h0000_0100, 4'hF);
        check("st_wen_t1", 32'(slv_wen_o), 32'h1);
        check("st_waddr_t1", slv_waddr_o, 32'h0000_0008);
        check("st_wdata_t1", slv_wdata_o, 32'h0000_0100);
        check("st_rsp_t1", 32'(rsp_valid_o), 32'd0);
        check("st_ready_t1", 32'(req_ready_o), 32'd0);
        tick();
        check("st_wen_t2", 32'(slv_wen_o), 32'h0);
        check("st_rsp_t2", 32'(rsp_valid_o), 32'd1);
        check("st_err_t2", 32'(rsp_err_o), 32'd0);
        check("st_mem", mem[0][2], 32'h0000_0100);
        tick();
        check("st_rsp_t3", 32'(rsp_valid_o), 32'd0);

        store_full(32'h1000_0004, 32'hDEAD_BEEF);
        store_full(32'h2000_000C, 32'h1122_3344);
        store_full(32'h0000_0014, 32'hCAFE_F00D);

        // Load from slave 1.
        wen_mark = wen_cnt;
        expect_rsp(1'b0, 32'hDEAD_BEEF);
        issue(1'b0, 32'h1000_0004, 32'h0, 4'h0);
        check("ld_raddr_t1", slv_raddr_o, 32'h1000_0004);
        check("ld_rsp_t1", 32'(rsp_valid_o), 32'd0);
        tick();
        check("ld_rsp_t2", 32'(rsp_valid_o), 32'd0);
        tick();
        check("ld_rsp_t3", 32'(rsp_valid_o), 32'd1);
        check("ld_rdata_t3", rsp_rdata_o, 32'hDEAD_BEEF);
        tick();
        check("ld_no_wen", 32'(wen_cnt - wen_mark), 32'd0);

        // Partial store on an unaligned address: byte 1 replaced.
        expect_rsp(1'b0, 32'h0);
        issue(1'b1, 32'h2000_000E, 32'h0000_AB00, 4'b0010);
        check("rmw_raddr_t1", slv_raddr_o, 32'h2000_000C);
        check("rmw_wen_t1", 32'(slv_wen_o), 32'h0);
        tick();
        check("rmw_wen_t2", 32'(slv_wen_o), 32'h0);
        tick();
        check("rmw_wen_t3", 32'(slv_wen_o), 32'h4);
        check("rmw_waddr_t3", slv_waddr_o, 32'h2000_000C);
        check("rmw_wdata_t3", slv_wdata_o, 32'h1122_AB44);
        check("rmw_rsp_t3", 32'(rsp_valid_o), 32'd0);
        tick();
        check("rmw_rsp_t4", 32'(rsp_valid_o), 32'd1);
        check("rmw_wen_t4", 32'(slv_wen_o), 32'h0);
        tick();
        check("rmw_mem", mem[2][3], 32'h1122_AB44);

        // Decode error: slave 5 does not exist.
        wen_mark = wen_cnt;
        expect_rsp(1'b1, 32'h0);
        issue(1'b0, 32'h5000_0000, 32'h0, 4'h0);
        check("err_raddr_hold", slv_raddr_o, 32'h2000_000C);
        check("err_rsp_t1", 32'(rsp_valid_o), 32'd0);
        tick();
        check("err_rsp_t2", 32'(rsp_valid_o), 32'd1);
        check("err_flag_t2", 32'(rsp_err_o), 32'd1);
        check("err_rdata_t2", rsp_rdata_o, 32'h0);
        tick();
        check("err_no_wen", 32'(wen_cnt - wen_mark), 32'd0);

        // Empty store: response only, memory untouched.
        wen_mark = wen_cnt;
        expect_rsp(1'b0, 32'h0);
        issue(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0);
        check("be0_wen_t1", 32'(slv_wen_o), 32'h0);
        tick();
        check("be0_rsp_t2", 32'(rsp_valid_o), 32'd1);
        tick();
        check("be0_no_wen", 32'(wen_cnt - wen_mark), 32'd0);
        check("be0_mem", mem[0][2], 32'h0000_0100);

        // Back-to-back: second request held valid during an in-flight load.
        wen_mark = wen_cnt;
        expect_rsp(1'b0, 32'hDEAD_BEEF);
        expect_rsp(1'b0, 32'h0);
        req_we_i    = 1'b0;
        req_addr_i  = 32'h1000_0004;
        req_be_i    = 4'h0;
        req_valid_i = 1'b1;
        check("b2b_ready_t0", 32'(req_ready_o), 32'd1);
        tick();
        req_we_i    = 1'b1;
        req_addr_i  = 32'h3000_0000;
        req_wdata_i = 32'h55AA_55AA;
        req_be_i    = 4'hF;
        check("b2b_ready_t1", 32'(req_ready_o), 32'd0);
        tick();
        check("b2b_ready_t2", 32'(req_ready_o), 32'd0);
        tick();
        check("b2b_ready_t3", 32'(req_ready_o), 32'd1);
        check("b2b_rsp_t3", 32'(rsp_valid_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        check("b2b_wen_s1", 32'(slv_wen_o), 32'h8);
        check("b2b_wdata_s1", slv_wdata_o, 32'h55AA_55AA);
        check("b2b_ready_s1", 32'(req_ready_o), 32'd0);
        tick();
        check("b2b_rsp_s2", 32'(rsp_valid_o), 32'd1);
        tick();
        tick();
        check("b2b_one_wen", 32'(wen_cnt - wen_mark), 32'd1);
        check("b2b_mem", mem[3][0], 32'h55AA_55AA);

        // Reset during RMW_D drops the request.
        wen_mark = wen_cnt;
        rsp_mark = rsp_cnt;
        issue(1'b1, 32'h0000_0014, 32'h0000_00FF, 4'b0001);
        tick();
        rst_i = 1'b1;
        #1;
        check("rstmid_wen", 32'(slv_wen_o), 32'h0);
        check("rstmid_rsp", 32'(rsp_valid_o), 32'd0);
        check("rstmid_raddr", slv_raddr_o, 32'h0);
        check("rstmid_ready", 32'(req_ready_o), 32'd1);
        tick();
        rst_i = 1'b0;
        repeat (4) tick();
        check("rstmid_no_wen", 32'(wen_cnt - wen_mark), 32'd0);
        check("rstmid_no_rsp", 32'(rsp_cnt - rsp_mark), 32'd0);
        check("rstmid_ready_after", 32'(req_ready_o), 32'd1);
        check("rstmid_mem", mem[0][5], 32'hCAFE_F00D);

        expect_rsp(1'b0, 32'hCAFE_F00D);
        issue(1'b0, 32'h0000_0014, 32'h0, 4'h0);
        repeat (3) tick();
        expect_rsp(1'b0, 32'h0000_0100);
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        repeat (3) tick();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("rsp_count", rsp_cnt, n_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
